prom_access_arbiter: RTL

// - Shares one 32x8 bipolar PROM (async read, enable + 5-bit address, 8-bit Q) between up to 4 clocked requesters.
// - Round-robin grant.
// - Drives PROM address/enable, waits a programmable number of clocks to cover address access and enable times, then latches Q.
// - Returns the latched byte to the granted requester with a one-cycle ack.
// - Sits between the colour/priority lookup logic and the PROM model on the video board.

---
 rtl/prom_access_arbiter_pkg.sv | 32 +++
 rtl/prom_access_arbiter_if.sv | 33 +++
 rtl/prom_access_arbiter_rr_pick.sv | 36 +++
 rtl/prom_access_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/prom_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// prom_access_arbiter_pkg
// Shared definitions for the PROM access arbiter and other board arbiters:
// FSM state encodings, requester/pointer limits, wait counter width and the
// modulo-NREQ pointer increment helper.
// -----------------------------------------------------------------------------
package prom_access_arbiter_pkg;

    localparam int MAX_REQ = 4;   // largest requester count supported
    localparam int CNT_W   = 4;   // wait counter width (WAIT_CYC 0..15)
    localparam int PTR_W   = 2;   // round-robin pointer / grant index width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Next round-robin pointer: one past the served requester, wrapping at
    // nreq (not at the 2-bit pointer range).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                  input int              nreq);
        logic [PTR_W-1:0] nxt;
        if (int'(p) >= nreq - 1) begin
            nxt = 2'd0;
        end else begin
            nxt = p + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/prom_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// prom_access_arbiter_if
// Bundles the requester-side bus (req/addr/ack/rdata), the PROM-side bus
// (prom_e/prom_a/prom_q) and the busy flag of the PROM access arbiter.
//   slave  : view of the arbiter (takes requests and PROM data, drives the rest)
//   master : view of the requesters plus PROM model around the arbiter
// -----------------------------------------------------------------------------
interface prom_access_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 8
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    ack;
    logic [NREQ*DW-1:0] rdata;
    logic               prom_e;
    logic [AW-1:0]      prom_a;
    logic [DW-1:0]      prom_q;
    logic               busy;

    modport slave (
        input  req, addr, prom_q,
        output ack, rdata, prom_e, prom_a, busy
    );

    modport master (
        output req, addr, prom_q,
        input  ack, rdata, prom_e, prom_a, busy
    );

endinterface

// File: rtl/prom_access_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// prom_access_arbiter_rr_pick
// Combinational round-robin picker: returns the index of the first set request
// bit at or after ptr, wrapping past NREQ-1 back to 0.
//   ptr       in   pointer, highest-priority requester (must be < NREQ)
//   req       in   request vector
//   grant     out  winning requester index (0 when nothing is requested)
//   any_valid out  at least one request bit is set
// -----------------------------------------------------------------------------
module prom_access_arbiter_rr_pick
    import prom_access_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [NREQ-1:0]  req,
    output logic [PTR_W-1:0] grant,
    output logic             any_valid
);

    // Two descending scans: the first yields the lowest set bit overall (the
    // wrap-around winner); the second overrides it with the lowest set bit at
    // or after ptr whenever one exists.
    always_comb begin
        grant     = 2'd0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            grant     = req[i] ? 2'(i) : grant;
            any_valid = req[i] ? 1'b1  : any_valid;
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            grant = (req[i] && (i >= int'(ptr))) ? 2'(i) : grant;
        end
    end

endmodule

// File: rtl/prom_access_arbiter.sv
// -----------------------------------------------------------------------------
// prom_access_arbiter
// Shares one asynchronous-read PROM between NREQ clocked requesters with a
// round-robin grant. An access drives prom_a/prom_e, waits WAIT_CYC extra
// clocks for address-access and enable time, captures prom_q into the
// granted requester's rdata slot and pulses that requester's ack once.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset (aborts an access without ack)
//   bus   slave modport: req/addr in, ack/rdata out, prom_e/prom_a out,
//         prom_q in, busy out (high whenever the FSM is not idle)
// Timing: req seen at edge N in idle -> ack at edge N+2+WAIT_CYC; one access
// every 3+WAIT_CYC clocks.
// -----------------------------------------------------------------------------
module prom_access_arbiter
    import prom_access_arbiter_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    prom_access_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [PTR_W-1:0]   ptr_q,    ptr_d;
    logic [PTR_W-1:0]   grant_q,  grant_d;
    logic               prom_e_q, prom_e_d;
    logic [AW-1:0]      prom_a_q, prom_a_d;
    logic [NREQ-1:0]    ack_q,    ack_d;
    logic [NREQ*DW-1:0] rdata_q,  rdata_d;
    logic               busy_q,   busy_d;

    logic [PTR_W-1:0]   pick_grant_s;
    logic               pick_valid_s;
    logic [AW-1:0]      addr_sel_s;

    prom_access_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .ptr       (ptr_q),
        .req       (bus.req),
        .grant     (pick_grant_s),
        .any_valid (pick_valid_s)
    );

    // Address of the requester the picker would grant this cycle.
    always_comb begin
        addr_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_sel_s = (pick_grant_s == 2'(i)) ? bus.addr[i*AW +: AW] : addr_sel_s;
        end
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        prom_e_d = prom_e_q;
        prom_a_d = prom_a_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    // Address is sampled only here; later addr changes are
                    // ignored for the rest of this access.
                    state_d  = ST_ACCESS;
                    grant_d  = pick_grant_s;
                    prom_a_d = addr_sel_s;
                    prom_e_d = 1'b1;
                    cnt_d    = WAIT_LD;
                    busy_d   = 1'b1;
                end else begin
                    prom_e_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end

            ST_ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_CAPTURE: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q == 2'(i)) begin
                        rdata_d[i*DW +: DW] = bus.prom_q;
                        ack_d[i]            = 1'b1;
                    end else begin
                        rdata_d[i*DW +: DW] = rdata_q[i*DW +: DW];
                        ack_d[i]            = 1'b0;
                    end
                end
                prom_e_d = 1'b0;
                ptr_d    = ptr_inc(grant_q, NREQ);
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                prom_e_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ptr_q    <= 2'd0;
            grant_q  <= 2'd0;
            prom_e_q <= 1'b0;
            prom_a_q <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            prom_e_q <= prom_e_d;
            prom_a_q <= prom_a_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.rdata  = rdata_q;
    assign bus.prom_e = prom_e_q;
    assign bus.prom_a = prom_a_q;
    assign bus.busy   = busy_q;

endmodule
